// File: rtl/pipe_pkg.sv
// Shared types and MEM/WB payload layout for the pipeline stage buffers.
// Latency: n/a (types, constants and a pure packing function only).
// Backpressure: n/a.
package pipe_pkg;

   // Stage fill level; the encoding is the Occupancy value driven on the port.
   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_t;

   // MEM/WB payload: {RegWrite, MemToReg, ReadData[31:0], ALUResult[31:0], RegDst[4:0]}
   localparam int MEMWB_W        = 71;
   localparam int MEMWB_RDST_LO  = 0;
   localparam int MEMWB_ALU_LO   = 5;
   localparam int MEMWB_RDATA_LO = 37;
   localparam int MEMWB_MEMTOREG = 69;
   localparam int MEMWB_REGWRITE = 70;

   function automatic logic [MEMWB_W-1:0] memwb_pack(
      input logic        regwrite,
      input logic        memtoreg,
      input logic [31:0] rdata,
      input logic [31:0] alu,
      input logic [4:0]  rdst
   );
      return {regwrite, memtoreg, rdata, alu, rdst};
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One payload register plus valid bit; used as main and skid entry of a stage.
// Latency: load visible one cycle after i_load.
// Backpressure: none; the owner decides when to load or clear (clear wins).
module pipe_slot #(
   parameter int DATA_W = 71
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_clear,
   input  logic              i_zero,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data
);

   logic              r_valid;
   logic [DATA_W-1:0] r_data;

   // Clear drops the entry (optionally zeroing it); load captures a new payload.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
         if (i_zero) r_data <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, flush and optional 2-entry skid.
// Latency: 1 cycle from accept to Out_Valid when empty; strict FIFO order.
// Backpressure: SKID=1 registered In_Ready (low only when both entries full); SKID=0 comb In_Ready.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W     = MEMWB_W,
   parameter int SKID       = 1,
   parameter int FLUSH_ZERO = 1,
   parameter int CNT_W      = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              In_Valid,
   output logic              In_Ready,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Valid,
   input  logic              Out_Ready,
   output logic [DATA_W-1:0] Out_Data,
   input  logic              Flush,
   output logic [1:0]        Occupancy,
   output logic [CNT_W-1:0]  Stall_Cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic              w_accept;
   logic              w_drain;
   logic              w_zero;
   logic              w_main_load;
   logic              w_main_clear;
   logic [DATA_W-1:0] w_main_din;
   logic [CNT_W-1:0]  r_stall_cnt;

   assign w_accept = In_Valid & In_Ready;
   assign w_drain  = Out_Valid & Out_Ready;
   // Payload bits are only zeroed by a flush, never by an ordinary drain.
   assign w_zero   = Flush && (FLUSH_ZERO != 0);

   pipe_slot #(.DATA_W(DATA_W)) u_main (
      .i_clk   (Clk),
      .i_rst_n (Rst_n),
      .i_load  (w_main_load),
      .i_clear (w_main_clear),
      .i_zero  (w_zero),
      .i_data  (w_main_din),
      .o_valid (Out_Valid),
      .o_data  (Out_Data)
   );

   generate
      if (SKID != 0) begin : g_skid
         occ_state_t        r_state;
         occ_state_t        w_state_nxt;
         logic              r_in_rdy;
         logic              w_skid_load;
         logic              w_skid_clear;
         logic              w_skid_vld;
         logic [DATA_W-1:0] w_skid_data;

         pipe_slot #(.DATA_W(DATA_W)) u_skid (
            .i_clk   (Clk),
            .i_rst_n (Rst_n),
            .i_load  (w_skid_load),
            .i_clear (w_skid_clear),
            .i_zero  (w_zero),
            .i_data  (In_Data),
            .o_valid (w_skid_vld),
            .o_data  (w_skid_data)
         );

         // Next fill level and slot controls; flush overrides every handshake.
         always_comb begin
            w_state_nxt  = r_state;
            w_main_load  = 1'b0;
            w_main_clear = 1'b0;
            w_main_din   = In_Data;
            w_skid_load  = 1'b0;
            w_skid_clear = 1'b0;
            if (Flush) begin
               w_state_nxt  = OCC_EMPTY;
               w_main_clear = 1'b1;
               w_skid_clear = 1'b1;
            end else begin
               case (r_state)
                  OCC_EMPTY: begin
                     if (w_accept) begin
                        w_main_load = 1'b1;
                        w_state_nxt = OCC_ONE;
                     end
                  end
                  OCC_ONE: begin
                     if (w_accept && w_drain) begin
                        w_main_load = 1'b1;
                     end else if (w_accept) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = OCC_TWO;
                     end else if (w_drain) begin
                        w_main_clear = 1'b1;
                        w_state_nxt  = OCC_EMPTY;
                     end
                  end
                  OCC_TWO: begin
                     if (w_drain) begin
                        w_main_load  = 1'b1;
                        w_main_din   = w_skid_data;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = OCC_ONE;
                     end
                  end
                  default: w_state_nxt = OCC_EMPTY;
               endcase
            end
         end

         // Fill-level state and its registered ready output.
         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               r_state  <= OCC_EMPTY;
               r_in_rdy <= 1'b1;
            end else begin
               r_state  <= w_state_nxt;
               r_in_rdy <= (w_state_nxt != OCC_TWO);
            end
         end

         assign In_Ready  = r_in_rdy;
         // Skid only ever holds data while main does, so the slot valids encode the level.
         assign Occupancy = {w_skid_vld, Out_Valid & ~w_skid_vld};
      end else begin : g_single
         assign In_Ready  = !Out_Valid | Out_Ready;
         assign Occupancy = {1'b0, Out_Valid};

         // Single register: load on accept, empty on drain without refill or on flush.
         always_comb begin
            w_main_din   = In_Data;
            w_main_load  = w_accept & ~Flush;
            w_main_clear = Flush | (w_drain & ~w_accept);
         end
      end
   endgenerate

   // Count back-pressured cycles, sticking at the maximum until reset.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_stall_cnt <= '0;
      end else if (Out_Valid && !Out_Ready && (r_stall_cnt != CNT_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign Stall_Cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid variant (CNT_W=4, zeroing flush) and single-register MEM/WB variant.
// Expected payloads are queued as stimulus is issued; a negedge monitor pops them on each drain.
// Status outputs (ready, occupancy, stall count) are compared against hand-derived constants.
module tb_pipe_stage_buf;
   import pipe_pkg::*;

   logic clk;
   logic rst_n;

   // Skid instance
   logic        s_ivld, s_irdy, s_ovld, s_ordy, s_flush;
   logic [70:0] s_idat, s_odat;
   logic [1:0]  s_occ;
   logic [3:0]  s_stall;
   // Single-register instance
   logic        n_ivld, n_irdy, n_ovld, n_ordy, n_flush;
   logic [70:0] n_idat, n_odat;
   logic [1:0]  n_occ;
   logic [15:0] n_stall;

   logic [70:0] sq[$];
   logic [70:0] nq[$];
   logic [70:0] s_exp, n_exp;
   logic [70:0] pkt1, pkt2, pkt3;
   int n_chk  = 0;
   int n_pass = 0;

   pipe_stage_buf #(.DATA_W(71), .SKID(1), .FLUSH_ZERO(1), .CNT_W(4)) dut_s (
      .Clk(clk), .Rst_n(rst_n),
      .In_Valid(s_ivld), .In_Ready(s_irdy), .In_Data(s_idat),
      .Out_Valid(s_ovld), .Out_Ready(s_ordy), .Out_Data(s_odat),
      .Flush(s_flush), .Occupancy(s_occ), .Stall_Cnt(s_stall)
   );

   pipe_stage_buf #(.DATA_W(71), .SKID(0), .FLUSH_ZERO(0), .CNT_W(16)) dut_n (
      .Clk(clk), .Rst_n(rst_n),
      .In_Valid(n_ivld), .In_Ready(n_irdy), .In_Data(n_idat),
      .Out_Valid(n_ovld), .Out_Ready(n_ordy), .Out_Data(n_odat),
      .Flush(n_flush), .Occupancy(n_occ), .Stall_Cnt(n_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: every drain must match the oldest expected payload.
   always @(negedge clk) begin
      if (rst_n && s_ovld && s_ordy) begin
         if (sq.size() == 0) begin
            n_chk++;
            $display("FAIL s_out_unexpected actual=%0h required=no output", s_odat);
         end else begin
            s_exp = sq.pop_front();
            chk("s_out_data", s_odat, s_exp);
         end
      end
      if (rst_n && n_ovld && n_ordy) begin
         if (nq.size() == 0) begin
            n_chk++;
            $display("FAIL n_out_unexpected actual=%0h required=no output", n_odat);
         end else begin
            n_exp = nq.pop_front();
            chk("n_out_data", n_odat, n_exp);
         end
      end
   end

   initial begin
      pkt1 = memwb_pack(1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 5'd9);
      pkt2 = 71'h55;
      pkt3 = memwb_pack(1'b0, 1'b1, 32'hCAFEF00D, 32'h0BADC0DE, 5'd31);
      rst_n = 1'b0;
      s_ivld = 0; s_ordy = 0; s_flush = 0; s_idat = '0;
      n_ivld = 0; n_ordy = 0; n_flush = 0; n_idat = '0;
      tick(); tick();
      // Reset state
      chk("rst_s_ovld", s_ovld, 0);
      chk("rst_s_odat", s_odat, 0);
      chk("rst_s_occ", s_occ, 0);
      chk("rst_s_stall", s_stall, 0);
      chk("rst_s_irdy", s_irdy, 1);
      chk("rst_n_ovld", n_ovld, 0);
      chk("rst_n_irdy", n_irdy, 1);
      rst_n = 1'b1;
      tick();

      // T2 streaming 0x1..0x10 with full throughput
      s_ordy = 1;
      for (int i = 1; i <= 16; i++) begin
         s_ivld = 1; s_idat = 71'(i); sq.push_back(71'(i));
         tick();
         chk("t2_latency", s_odat, i);
         chk("t2_irdy", s_irdy, 1);
      end
      s_ivld = 0;
      tick();
      chk("t2_occ_end", s_occ, 0);
      chk("t2_ovld_end", s_ovld, 0);
      chk("t2_hold_data", s_odat, 16);

      // T3 back-pressure: 0xA, 0xB fill both entries
      s_ordy = 0;
      s_ivld = 1; s_idat = 71'hA; sq.push_back(71'hA);
      tick();
      chk("t3_irdy_one", s_irdy, 1);
      s_idat = 71'hB; sq.push_back(71'hB);
      tick();
      chk("t3_occ_two", s_occ, 2);
      chk("t3_irdy_full", s_irdy, 0);
      s_idat = 71'hD;            // offered while full: must not be taken
      tick();
      chk("t3_occ_hold", s_occ, 2);
      chk("t3_stall", s_stall, 2);
      s_ivld = 0; s_ordy = 1;
      tick();
      chk("t3_occ_after_drain", s_occ, 1);
      chk("t3_irdy_reopen", s_irdy, 1);
      tick();
      chk("t3_occ_empty", s_occ, 0);

      // T4 flush with both entries full and a payload offered
      s_ordy = 0;
      s_ivld = 1; s_idat = 71'h11; sq.push_back(71'h11);
      tick();
      s_idat = 71'h12; sq.push_back(71'h12);
      tick();
      chk("t4_occ_two", s_occ, 2);
      s_flush = 1; s_idat = 71'hC;
      tick();
      sq.delete();
      s_flush = 0; s_ivld = 0;
      chk("t4_ovld", s_ovld, 0);
      chk("t4_occ", s_occ, 0);
      chk("t4_irdy", s_irdy, 1);
      chk("t4_zero", s_odat, 0);
      chk("t4_stall", s_stall, 4);
      s_ordy = 1;
      tick(); tick();
      // Drain coinciding with flush is still delivered
      s_ordy = 0;
      s_ivld = 1; s_idat = 71'h13; sq.push_back(71'h13);
      tick();
      s_ivld = 0; s_flush = 1; s_ordy = 1;
      tick();
      s_flush = 0;
      sq.delete();
      chk("t4b_occ", s_occ, 0);
      chk("t4b_stall", s_stall, 4);

      // T5 stall counter saturation at 15
      s_ordy = 0;
      s_ivld = 1; s_idat = 71'h21; sq.push_back(71'h21);
      tick();
      s_ivld = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         chk("t5_stall", s_stall, (4 + i > 15) ? 15 : 4 + i);
      end
      s_ordy = 1;
      tick();
      chk("t5_stall_hold", s_stall, 15);

      // T1 asynchronous reset with two entries held
      s_ordy = 0;
      s_ivld = 1; s_idat = 71'h31; sq.push_back(71'h31);
      tick();
      s_idat = 71'h32; sq.push_back(71'h32);
      tick();
      s_ivld = 0;
      chk("t1_occ_pre", s_occ, 2);
      #2 rst_n = 1'b0;
      #1;
      sq.delete();
      chk("t1_ovld", s_ovld, 0);
      chk("t1_odat", s_odat, 0);
      chk("t1_occ", s_occ, 0);
      chk("t1_stall", s_stall, 0);
      chk("t1_irdy", s_irdy, 1);
      tick();
      rst_n = 1'b1;
      s_ordy = 1;
      tick(); tick(); tick();
      chk("t1_irdy_after", s_irdy, 1);
      chk("t1_occ_after", s_occ, 0);

      // T6 single register with MEM/WB packing
      n_ordy = 0;
      n_ivld = 1; n_idat = pkt1; nq.push_back(pkt1);
      #1;
      chk("t6_irdy_empty", n_irdy, 1);
      tick();
      chk("t6_irdy_blocked", n_irdy, 0);
      chk("t6_regwrite", n_odat[MEMWB_REGWRITE], 1);
      chk("t6_memtoreg", n_odat[MEMWB_MEMTOREG], 0);
      chk("t6_rdata", n_odat[MEMWB_RDATA_LO +: 32], 32'hDEADBEEF);
      chk("t6_alu", n_odat[MEMWB_ALU_LO +: 32], 32'h12345678);
      chk("t6_rdst", n_odat[MEMWB_RDST_LO +: 5], 9);
      n_idat = pkt2;
      tick();
      chk("t6_hold", n_odat, pkt1);
      chk("t6_occ", n_occ, 1);
      n_ordy = 1; nq.push_back(pkt2);
      #1;
      chk("t6_irdy_comb", n_irdy, 1);
      tick();
      chk("t6_pass_through", n_odat, pkt2);
      n_ivld = 0;
      tick();
      chk("t6_ovld_empty", n_ovld, 0);
      n_ordy = 0;
      n_ivld = 1; n_idat = pkt3; nq.push_back(pkt3);
      tick();
      n_ivld = 0; n_flush = 1;
      tick();
      n_flush = 0;
      nq.delete();
      chk("t6_flush_ovld", n_ovld, 0);
      chk("t6_flush_occ", n_occ, 0);
      chk("t6_flush_keep", n_odat, pkt3);
      chk("t6_stall", n_stall, 2);
      chk("t6_flush_irdy", n_irdy, 1);
      tick(); tick();

      chk("s_queue_drained", sq.size(), 0);
      chk("n_queue_drained", nq.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
